// File: rtl/router_pkg.sv
// Shared router types and helpers for the VC input buffer.
package router_pkg;

  typedef enum logic [1:0] {
    BODY     = 2'b00,
    TAIL     = 2'b01,
    HEADER   = 2'b10,
    HEADTAIL = 2'b11
  } flit_type_t;

  // Type field offsets below the flit MSB: bits [Width-1:Width-2]
  localparam int FlitTypeMsb = 1;
  localparam int FlitTypeLsb = 2;

  function automatic int vc_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/router_vc_queue.sv
// Single virtual-channel FIFO: storage, head/tail pointers, occupancy.
module router_vc_queue
  import router_pkg::*;
#(
  parameter  int Depth    = 4,
  parameter  int Width    = 66,
  parameter  int AfMargin = 1,
  localparam int CntW     = $clog2(Depth + 1),
  localparam int PtrW     = $clog2(Depth)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0] count_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            afull_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Binary pointers wrap explicitly so Depth need not be a power of two
  function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop_i)  head_d = bump(head_q);
    if (push_i) tail_d = bump(tail_q);
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[tail_q] <= data_i;
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign afull_o = (cnt_q >= CntW'(Depth - AfMargin));

  a_ptr_rng: assert property (@(posedge clk) disable iff (rst)
    (int'(head_q) < Depth) && (int'(tail_q) < Depth));

  a_cnt_rng: assert property (@(posedge clk) disable iff (rst)
    (int'(cnt_q) <= Depth) && !(full_o && empty_o));

  a_cnt_ptr: assert property (@(posedge clk) disable iff (rst)
    full_o ||
    (int'(cnt_q) == (int'(tail_q) + Depth - int'(head_q)) % Depth));

endmodule

// File: rtl/router_vc_fifo.sv
// Router input buffer: NumVc independent FIFOs behind one shared
// write port and one shared read port, with same-VC bypass.
module router_vc_fifo
  import router_pkg::*;
#(
  parameter  int NumVc        = 2,
  parameter  int Depth        = 4,
  parameter  int Width        = 66,
  parameter  bit BypassEnable = 1'b1,
  parameter  int AfMargin     = 1,
  localparam int VcW          = vc_w(NumVc),
  localparam int CntW         = $clog2(Depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrreq,
  input  logic [VcW-1:0]        wr_vc,
  input  logic [Width-1:0]      data_in,
  input  logic                  rdreq,
  input  logic [VcW-1:0]        rd_vc,
  output logic [Width-1:0]      data_out,
  output logic [NumVc-1:0]      empty,
  output logic [NumVc-1:0]      full,
  output logic [NumVc-1:0]      almost_full,
  output logic [NumVc*CntW-1:0] count,
  output logic                  wr_err,
  output logic                  rd_err
);

  logic [NumVc-1:0] wr_hit, rd_hit, byp_v;
  logic [NumVc-1:0] valid_read, valid_write;
  logic             bypass;
  logic [Width-1:0] head [NumVc];
  logic [Width-1:0] head_sel;

  for (genvar v = 0; v < NumVc; v++) begin : g_vc
    assign wr_hit[v] = wrreq & (wr_vc == VcW'(v));
    assign rd_hit[v] = rdreq & (rd_vc == VcW'(v));
    assign byp_v[v]  = BypassEnable & empty[v] & rd_hit[v] & wr_hit[v];
    assign valid_read[v] = rd_hit[v] & ~empty[v];
    // A full VC still accepts a push when it is popped the same cycle
    assign valid_write[v] = wr_hit[v] & ~bypass &
                            (~full[v] | valid_read[v]);

    router_vc_queue #(
      .Depth   (Depth),
      .Width   (Width),
      .AfMargin(AfMargin)
    ) u_q (
      .clk    (clk),
      .rst    (rst),
      .push_i (valid_write[v]),
      .pop_i  (valid_read[v]),
      .data_i (data_in),
      .head_o (head[v]),
      .count_o(count[v*CntW +: CntW]),
      .empty_o(empty[v]),
      .full_o (full[v]),
      .afull_o(almost_full[v])
    );
  end

  assign bypass = |byp_v;

  always_comb begin
    head_sel = '0;
    for (int v = 0; v < NumVc; v++) begin
      if (rd_vc == VcW'(v)) head_sel = head[v];
    end
  end

  always_comb begin
    data_out = head_sel;
    if (rst) data_out = BypassEnable ? data_in : '0;
    else if (bypass) data_out = data_in;
  end

  assign wr_err = wrreq & ~(|valid_write | bypass);
  assign rd_err = rdreq & ~(|valid_read | bypass);

endmodule

// File: tb/tb_router_vc_fifo.sv
// Directed vector table plus sequences for reset, bypass-off,
// interleaving and Depth=3/NumVc=3 random traffic.
module tb_router_vc_fifo;

  typedef struct {
    bit          wr;
    int          wv;
    logic [65:0] din;
    bit          rd;
    int          rv;
    bit          chk;
    logic [65:0] dout;
    logic [1:0]  emp;
    logic [1:0]  ful;
    logic [1:0]  af;
    int          c0;
    int          c1;
    bit          we;
    bit          re;
  } vec_t;

  logic clk, rst;

  logic        a_wr, a_rd, a_we, a_re;
  logic [0:0]  a_wv, a_rv;
  logic [65:0] a_din, a_do;
  logic [1:0]  a_emp, a_ful, a_af;
  logic [5:0]  a_cnt;

  logic        b_wr, b_rd, b_we, b_re;
  logic [0:0]  b_wv, b_rv;
  logic [65:0] b_din, b_do;
  logic [1:0]  b_emp, b_ful, b_af;
  logic [5:0]  b_cnt;

  logic        c_wr, c_rd, c_we, c_re;
  logic [1:0]  c_wv, c_rv;
  logic [65:0] c_din, c_do;
  logic [2:0]  c_emp, c_ful, c_af;
  logic [5:0]  c_cnt;

  int checks = 0;
  int failures = 0;

  vec_t        tv [28];
  logic [65:0] sq [2][$];
  logic [65:0] mq [3][$];

  router_vc_fifo u_a (
    .clk(clk), .rst(rst), .wrreq(a_wr), .wr_vc(a_wv), .data_in(a_din),
    .rdreq(a_rd), .rd_vc(a_rv), .data_out(a_do), .empty(a_emp),
    .full(a_ful), .almost_full(a_af), .count(a_cnt),
    .wr_err(a_we), .rd_err(a_re)
  );

  router_vc_fifo #(.BypassEnable(1'b0)) u_b (
    .clk(clk), .rst(rst), .wrreq(b_wr), .wr_vc(b_wv), .data_in(b_din),
    .rdreq(b_rd), .rd_vc(b_rv), .data_out(b_do), .empty(b_emp),
    .full(b_ful), .almost_full(b_af), .count(b_cnt),
    .wr_err(b_we), .rd_err(b_re)
  );

  router_vc_fifo #(.NumVc(3), .Depth(3)) u_c (
    .clk(clk), .rst(rst), .wrreq(c_wr), .wr_vc(c_wv), .data_in(c_din),
    .rdreq(c_rd), .rd_vc(c_rv), .data_out(c_do), .empty(c_emp),
    .full(c_ful), .almost_full(c_af), .count(c_cnt),
    .wr_err(c_we), .rd_err(c_re)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [65:0] act,
                     input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input bit wr, input int wv, input logic [65:0] din,
    input bit rd, input int rv, input bit c, input logic [65:0] d,
    input logic [1:0] e, input logic [1:0] f, input logic [1:0] a,
    input int c0, input int c1, input bit we, input bit re);
    vec_t r;
    r.wr = wr; r.wv = wv; r.din = din; r.rd = rd; r.rv = rv;
    r.chk = c; r.dout = d; r.emp = e; r.ful = f; r.af = a;
    r.c0 = c0; r.c1 = c1; r.we = we; r.re = re;
    return r;
  endfunction

  initial begin
    bit vr, vw, rh, wh, byp, e_we, e_re;
    int wv, rv;
    logic [65:0] e_do;
    logic [5:0]  e_cnt;
    logic [2:0]  e_emp, e_ful;

    //        wr v din   rd v  chk dout   emp    ful    af    c0 c1 we re
    tv[0]  = mk(0,0,0,    0,0, 0,0,     2'b11,2'b00,2'b00, 0,0, 0,0);
    tv[1]  = mk(1,0,'hA,  0,0, 0,0,     2'b11,2'b00,2'b00, 0,0, 0,0);
    tv[2]  = mk(1,0,'hB,  0,0, 0,0,     2'b10,2'b00,2'b00, 1,0, 0,0);
    tv[3]  = mk(1,0,'hC,  0,0, 0,0,     2'b10,2'b00,2'b00, 2,0, 0,0);
    tv[4]  = mk(1,0,'hD,  0,0, 0,0,     2'b10,2'b00,2'b01, 3,0, 0,0);
    tv[5]  = mk(1,0,'hF,  0,0, 0,0,     2'b10,2'b01,2'b01, 4,0, 1,0);
    tv[6]  = mk(0,0,0,    0,0, 0,0,     2'b10,2'b01,2'b01, 4,0, 0,0);
    tv[7]  = mk(0,0,0,    1,0, 1,'hA,   2'b10,2'b01,2'b01, 4,0, 0,0);
    tv[8]  = mk(0,0,0,    1,0, 1,'hB,   2'b10,2'b00,2'b01, 3,0, 0,0);
    tv[9]  = mk(0,0,0,    1,0, 1,'hC,   2'b10,2'b00,2'b00, 2,0, 0,0);
    tv[10] = mk(0,0,0,    1,0, 1,'hD,   2'b10,2'b00,2'b00, 1,0, 0,0);
    tv[11] = mk(0,0,0,    1,0, 0,0,     2'b11,2'b00,2'b00, 0,0, 0,1);
    tv[12] = mk(1,0,'hA,  0,0, 0,0,     2'b11,2'b00,2'b00, 0,0, 0,0);
    tv[13] = mk(1,0,'hB,  0,0, 0,0,     2'b10,2'b00,2'b00, 1,0, 0,0);
    tv[14] = mk(1,0,'hC,  0,0, 0,0,     2'b10,2'b00,2'b00, 2,0, 0,0);
    tv[15] = mk(1,0,'hD,  0,0, 0,0,     2'b10,2'b00,2'b01, 3,0, 0,0);
    tv[16] = mk(1,0,'hE,  1,0, 1,'hA,   2'b10,2'b01,2'b01, 4,0, 0,0);
    tv[17] = mk(0,0,0,    0,0, 0,0,     2'b10,2'b01,2'b01, 4,0, 0,0);
    tv[18] = mk(0,0,0,    1,0, 1,'hB,   2'b10,2'b01,2'b01, 4,0, 0,0);
    tv[19] = mk(0,0,0,    1,0, 1,'hC,   2'b10,2'b00,2'b01, 3,0, 0,0);
    tv[20] = mk(0,0,0,    1,0, 1,'hD,   2'b10,2'b00,2'b00, 2,0, 0,0);
    tv[21] = mk(0,0,0,    1,0, 1,'hE,   2'b10,2'b00,2'b00, 1,0, 0,0);
    tv[22] = mk(0,0,0,    0,0, 0,0,     2'b11,2'b00,2'b00, 0,0, 0,0);
    tv[23] = mk(1,1,'h55, 1,1, 1,'h55,  2'b11,2'b00,2'b00, 0,0, 0,0);
    tv[24] = mk(0,0,0,    0,0, 0,0,     2'b11,2'b00,2'b00, 0,0, 0,0);
    tv[25] = mk(1,1,'h77, 1,0, 0,0,     2'b11,2'b00,2'b00, 0,0, 0,1);
    tv[26] = mk(0,0,0,    1,1, 1,'h77,  2'b01,2'b00,2'b00, 0,1, 0,0);
    tv[27] = mk(0,0,0,    0,0, 0,0,     2'b11,2'b00,2'b00, 0,0, 0,0);

    rst = 1'b1;
    a_wr = 0; a_rd = 0; a_wv = 0; a_rv = 0; a_din = 66'h123;
    b_wr = 0; b_rd = 0; b_wv = 0; b_rv = 0; b_din = 66'h456;
    c_wr = 0; c_rd = 0; c_wv = 0; c_rv = 0; c_din = 0;

    #2;
    chk("rst_empty", a_emp, 2'b11);
    chk("rst_full", a_ful, 2'b00);
    chk("rst_af", a_af, 2'b00);
    chk("rst_count", a_cnt, 6'd0);
    chk("rst_wr_err", a_we, 1'b0);
    chk("rst_rd_err", a_re, 1'b0);
    chk("rst_dout_byp", a_do, 66'h123);
    chk("rst_dout_nobyp", b_do, 66'h0);
    chk("rst_c_empty", c_emp, 3'b111);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      a_wr = tv[i].wr; a_wv = 1'(tv[i].wv); a_din = tv[i].din;
      a_rd = tv[i].rd; a_rv = 1'(tv[i].rv);
      #2;
      if (tv[i].chk) chk($sformatf("v%0d_dout", i), a_do, tv[i].dout);
      chk($sformatf("v%0d_empty", i), a_emp, tv[i].emp);
      chk($sformatf("v%0d_full", i), a_ful, tv[i].ful);
      chk($sformatf("v%0d_af", i), a_af, tv[i].af);
      chk($sformatf("v%0d_count", i), a_cnt,
          {3'(tv[i].c1), 3'(tv[i].c0)});
      chk($sformatf("v%0d_wr_err", i), a_we, tv[i].we);
      chk($sformatf("v%0d_rd_err", i), a_re, tv[i].re);
    end

    // Reset while VC1 holds three flits
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_wr = 1; a_wv = 1; a_rd = 0; a_din = 66'(i + 1);
    end
    @(negedge clk);
    a_wr = 0; a_din = 66'h99;
    #2;
    chk("mid_pre_cnt1", a_cnt[5:3], 3'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_cnt1", a_cnt[5:3], 3'd0);
    chk("mid_rst_empty", a_emp, 2'b11);
    chk("mid_rst_dout", a_do, 66'h99);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("mid_post_empty", a_emp, 2'b11);

    // Alternate VC roles every cycle; pointers wrap several times
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wv = i % 2;
      rv = 1 - wv;
      a_wr = 1; a_rd = 1; a_wv = 1'(wv); a_rv = 1'(rv);
      a_din = {2'(i % 4), 32'(wv), 32'(i)};
      vr = sq[rv].size() > 0;
      vw = sq[wv].size() < 4;
      #2;
      chk($sformatf("il%0d_rd_err", i), a_re, !vr);
      chk($sformatf("il%0d_wr_err", i), a_we, !vw);
      if (vr) chk($sformatf("il%0d_dout", i), a_do, sq[rv][0]);
      chk($sformatf("il%0d_count", i), a_cnt,
          {3'(sq[1].size()), 3'(sq[0].size())});
      if (vr) void'(sq[rv].pop_front());
      if (vw) sq[wv].push_back(a_din);
    end
    @(negedge clk);
    a_wr = 0; a_rd = 0;

    // Bypass disabled: same-VC read+write on an empty VC
    b_wr = 1; b_rd = 1; b_wv = 1; b_rv = 1; b_din = 66'h55;
    #2;
    chk("nb_rd_err", b_re, 1'b1);
    chk("nb_wr_err", b_we, 1'b0);
    chk("nb_cnt_same", b_cnt[5:3], 3'd0);
    @(negedge clk);
    b_wr = 0; b_rd = 0;
    #2;
    chk("nb_cnt_next", b_cnt[5:3], 3'd1);
    @(negedge clk);
    b_rd = 1; b_rv = 1;
    #2;
    chk("nb_dout", b_do, 66'h55);
    chk("nb_rd_ok", b_re, 1'b0);
    @(negedge clk);
    b_rd = 0;

    // Depth=3, NumVc=3 random traffic against a queue model
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      c_wr = ($urandom_range(0, 3) != 0);
      c_wv = 2'($urandom_range(0, 3));
      c_rd = ($urandom_range(0, 2) != 0);
      c_rv = 2'($urandom_range(0, 3));
      c_din = {2'($urandom), $urandom, $urandom};
      rh = c_rd && (c_rv < 2'd3);
      wh = c_wr && (c_wv < 2'd3);
      vr = 0; byp = 0; vw = 0; e_do = '0;
      if (rh) begin
        vr = mq[c_rv].size() > 0;
        byp = wh && (c_wv == c_rv) && !vr;
        if (vr) e_do = mq[c_rv][0];
      end
      if (byp) e_do = c_din;
      if (wh) vw = !byp && (mq[c_wv].size() < 3 || (vr && c_wv == c_rv));
      e_we = c_wr && !(vw || byp);
      e_re = c_rd && !(vr || byp);
      for (int v = 0; v < 3; v++) begin
        e_cnt[v*2 +: 2] = 2'(mq[v].size());
        e_emp[v] = (mq[v].size() == 0);
        e_ful[v] = (mq[v].size() == 3);
      end
      #2;
      chk($sformatf("r%0d_wr_err", i), c_we, e_we);
      chk($sformatf("r%0d_rd_err", i), c_re, e_re);
      if (vr || byp) chk($sformatf("r%0d_dout", i), c_do, e_do);
      chk($sformatf("r%0d_count", i), c_cnt, e_cnt);
      chk($sformatf("r%0d_empty", i), c_emp, e_emp);
      chk($sformatf("r%0d_full", i), c_ful, e_ful);
      if (vr) void'(mq[c_rv].pop_front());
      if (vw) mq[c_wv].push_back(c_din);
    end
    @(negedge clk);
    c_wr = 0; c_rd = 0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
